// File: rtl/alu_exec_cdb_pkg.sv
// Shared definitions for the ALU execute / CDB block: widths, op-codes,
// FIFO entry layout and the combinational ALU function.
package alu_exec_cdb_pkg;

  localparam int ALU_OP_WIDTH    = 4;
  localparam int ROB_ENTRY_WIDTH = 5;
  localparam int ENTRY_W         = ROB_ENTRY_WIDTH + 32;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  // One completed result: ROB tag in the upper bits, data in the lower 32.
  typedef struct packed {
    logic [ROB_ENTRY_WIDTH-1:0] idx;
    logic [31:0]                data;
  } cdb_entry_t;

  // Shifts use only the low five bits of the second operand.
  function automatic logic [31:0] alu_compute(input logic [ALU_OP_WIDTH-1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      OP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'd0, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_cdb_if.sv
// Issue-side and CDB-side signal bundle for alu_exec_cdb.
//
// Handshake: an issue cycle carries an op exactly when Dest_in != 0. There is
// no ready signal; the producer cannot be stalled, so it must stop issuing
// while almost_full is high. On the CDB side CDB_ALU_ROB_index != 0 marks a
// broadcast that lasts exactly one cycle; cdb_grant permits the broadcast
// that the next rising edge loads.
interface alu_exec_cdb_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import alu_exec_cdb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                       rollback;
  logic [ALU_OP_WIDTH-1:0]    Op_in;
  logic [31:0]                Vj_in;
  logic [31:0]                Vk_in;
  logic [ROB_ENTRY_WIDTH-1:0] Dest_in;
  logic                       cdb_grant;
  logic [ROB_ENTRY_WIDTH-1:0] CDB_ALU_ROB_index;
  logic [31:0]                CDB_ALU_data;
  logic                       almost_full;
  logic                       overflow_err;
  logic [CNT_W-1:0]           dbg_count;

  modport master (
    output rollback, Op_in, Vj_in, Vk_in, Dest_in, cdb_grant,
    input  CDB_ALU_ROB_index, CDB_ALU_data, almost_full, overflow_err, dbg_count
  );

  modport slave (
    input  rollback, Op_in, Vj_in, Vk_in, Dest_in, cdb_grant,
    output CDB_ALU_ROB_index, CDB_ALU_data, almost_full, overflow_err, dbg_count
  );

endinterface

// File: rtl/alu_exec_cdb_result_fifo.sv
// alu_result_fifo: small circular buffer of completed ALU results.
// A push at full is accepted only when a pop happens on the same edge;
// otherwise it is dropped. flush empties the buffer and wins over push/pop.
module alu_result_fifo
  import alu_exec_cdb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = ENTRY_W,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_q];

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_cdb.sv
// alu_exec_cdb: ALU functional unit with a result FIFO driving the ALU CDB.
// Optional macro ALU_CDB_BYPASS_EN: when the FIFO is empty and the CDB is
// granted, a fresh result goes straight to the CDB registers (1-cycle path).
module alu_exec_cdb
  import alu_exec_cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AF_SLACK   = 2
) (
  input logic           clk,
  input logic           rst_n,
  alu_exec_cdb_if.slave bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int AF_TH_I = FIFO_DEPTH - AF_SLACK;
  // A non-positive threshold means the flag is permanently raised.
  localparam bit                AF_ALWAYS = (AF_TH_I <= 0);
  localparam logic [CNT_W-1:0]  AF_TH     = AF_ALWAYS ? '0 : CNT_W'(AF_TH_I);

  logic [31:0]      result;
  logic             in_valid, bypass, push, pop;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [ENTRY_W-1:0] head_raw;
  cdb_entry_t       head, cdb_d, cdb_q;
  logic             ovf_d, ovf_q;

  assign in_valid = (bus.Dest_in != '0);
  assign result   = alu_compute(bus.Op_in, bus.Vj_in, bus.Vk_in);
  assign head     = cdb_entry_t'(head_raw);

`ifdef ALU_CDB_BYPASS_EN
  assign bypass = in_valid && empty && bus.cdb_grant && !bus.rollback;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && !bus.rollback && !bypass;
  assign pop  = bus.cdb_grant && !empty && !bus.rollback;

  alu_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.rollback),
    .wdata ({bus.Dest_in, result}),
    .head  (head_raw),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // CDB register source: FIFO head, bypassed result, or idle zero.
  always_comb begin
    cdb_d = '0;
    ovf_d = ovf_q;
    if (!bus.rollback) begin
      if (pop) begin
        cdb_d = head;
      end else if (bypass) begin
        cdb_d.idx  = bus.Dest_in;
        cdb_d.data = result;
      end
      if (push && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // CDB output registers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cdb_q <= cdb_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.CDB_ALU_ROB_index = cdb_q.idx;
  assign bus.CDB_ALU_data      = cdb_q.data;
  assign bus.almost_full       = AF_ALWAYS || (count >= AF_TH);
  assign bus.overflow_err      = ovf_q;
  assign bus.dbg_count         = count;

endmodule

// File: doc/alu_exec_cdb.md
Name: alu_exec_cdb

Overview:
- ALU functional unit fed by the ALU reservation station's issue outputs (op, operands, destination ROB index).
- Computes the result, buffers completed results in a small FIFO, and drives the dedicated ALU CDB channel (ROB index plus data), gated by a CDB grant.
- Sits between the ALU reservation station and every CDB consumer (reservation stations, ROB, LSQ).
- Provides an almost-full backpressure flag to issue logic, because the reservation station cannot stall its output.

Parameters:
- FIFO_DEPTH, 4, number of buffered completed results.
- AF_SLACK, 2, almost_full asserts when occupancy >= FIFO_DEPTH - AF_SLACK; covers in-flight issue and reservation-station output register.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rollback  in  1  synchronous flush from the ROB on misprediction.
- Op_in  in  ALU_OP_WIDTH  operation code from the reservation station.
- Vj_in  in  32  first operand.
- Vk_in  in  32  second operand.
- Dest_in  in  ROB_ENTRY_WIDTH  destination ROB index; 0 = no operation this cycle.
- cdb_grant  in  1  CDB arbiter permits a broadcast on the next edge.
- CDB_ALU_ROB_index  out  ROB_ENTRY_WIDTH  broadcast tag, registered; 0 = idle.
- CDB_ALU_data  out  32  broadcast result, registered.
- almost_full  out  1  issue logic must stop issuing ALU ops; combinational from occupancy.
- overflow_err  out  1  sticky; a result was dropped at a full FIFO.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers and count 0, CDB_ALU_ROB_index = 0, CDB_ALU_data = 0, overflow_err = 0. almost_full follows count, so 0 (unless FIFO_DEPTH - AF_SLACK <= 0).
- Valid input: Dest_in != 0. Result is computed combinationally in the same cycle.
- Operations:
  - ADD, SUB: modulo 2^32.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: shift amount = Vk_in[4:0].
  - SLT: signed compare, result 32'd1 or 32'd0.
  - SLTU: unsigned compare, result 32'd1 or 32'd0.
  - Unknown op: result 0.
- Push: a valid input writes {Dest_in, result} at the FIFO tail on the edge.
- Pop, every edge:
  - If cdb_grant and FIFO non-empty: head moves into the CDB output registers and the FIFO pops.
  - Otherwise the CDB registers load 0 (index and data). Each result is broadcast for exactly one cycle.
- Latency (no optional feature): input valid in cycle t -> on CDB in cycle t+2 at earliest (FIFO empty, grant high in t+1).
- Ordering: strict FIFO. Results broadcast in issue order.
- Simultaneous push and pop: allowed at any occupancy, including full; count unchanged.
- Push at full without a pop: result dropped, overflow_err set (stays set until reset), FIFO unchanged.
- Pop with empty FIFO: no effect; CDB idle.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- rollback high (synchronous, overrides push and pop):
  - FIFO emptied; input that cycle discarded.
  - CDB registers load 0.
  - overflow_err is not cleared.
- rst_n assertion mid-operation: immediate clear of all state, independent of clk.

Optional Feature:
- Macro: ALU_CDB_BYPASS_EN.
- Defined: when FIFO is empty, input is valid, cdb_grant is high and rollback is low, the computed result loads the CDB registers directly that edge without entering the FIFO. Latency becomes 1 cycle (input in t -> CDB in t+1).
- Defined: if the FIFO is non-empty, the head pops as normal and the input is pushed. Ordering is preserved.
- Not defined: every result passes through the FIFO; minimum latency is 2 cycles.

Decomposition:
- Shared defines header holds:
  - ALU_OP_WIDTH, ROB_ENTRY_WIDTH;
  - ALU op-code constants (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU);
  - the FIFO entry width, ROB_ENTRY_WIDTH + 32.
- Sub-module alu_result_fifo: parameterised FIFO_DEPTH, ports push/pop/flush, head data, count, full, empty.
- Top level holds: ALU datapath, CDB output registers, almost_full, overflow_err, bypass mux.

Test Plan:
- Reset then idle, grant=1: ADD Vj=5 Vk=7 Dest=3 in cycle 1 -> CDB index 3, data 12 in cycle 3 (cycle 2 with ALU_CDB_BYPASS_EN); CDB index 0 the following cycle.
- Op coverage, grant=1 (Vj, Vk -> expected data):
  - SUB 0 - 1 -> 0xFFFFFFFF
  - SRA 0x80000000 by Vk=0x21 -> 0xC0000000
  - SLT -1 vs 1 -> 1
  - SLTU -1 vs 1 -> 0
  - unknown op -> 0
- Hold grant=0 and issue Dest=1,2,3:
  - almost_full=1 after the second push (depth 4, slack 2);
  - raise grant -> tags 1, 2, 3 broadcast on consecutive cycles in order.
- Grant=0, issue 5 ops -> fifth dropped, overflow_err=1. Push and pop at full in the same cycle -> count stays 4, no error.
- FIFO holding 3 entries, rollback pulsed alongside a valid input -> CDB idle next cycle, FIFO empty, almost_full=0, no later broadcast of those tags.
- Drive rst_n low asynchronously between edges while entries are pending -> CDB outputs go to 0 immediately; no broadcasts after release.
